// File: rtl/idelayctrl_mgr.sv
// Reset/ready manager for a bank of IDELAYCTRL instances: sequences a minimum-width
// controller reset, waits for every enabled group to be ready, and retries before faulting.
module idelayctrl_mgr #(
    parameter int                 NUM_GRP     = 1,
    parameter logic [NUM_GRP-1:0] GRP_MASK    = '1,
    parameter int                 RST_CYCLES  = 16,
    parameter int                 RDY_TIMEOUT = 4096,
    parameter int                 MAX_RETRY   = 3
) (
    input  logic               REFCLK,
    input  logic               RST,
    input  logic               recal,
    input  logic [NUM_GRP-1:0] ctrl_rdy,
    output logic [NUM_GRP-1:0] ctrl_rst,
    output logic               RDY,
    output logic [NUM_GRP-1:0] grp_rdy,
    output logic               fault,
    output logic [7:0]         loss_cnt,
    output logic [1:0]         dbg_state,
    output logic [3:0]         dbg_retry
);

    localparam int CNT_MAX = (RST_CYCLES > RDY_TIMEOUT) ? RST_CYCLES : RDY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_END  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_END  = CW'(RDY_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_WAIT   = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [3:0]         retry, retry_nxt;
    logic               loss_inc;
    logic [NUM_GRP-1:0] rdy_m, rdy_s;
    logic               all_rdy;

    // ctrl_rdy is asynchronous to REFCLK; two flops per bit before any use.
    always_ff @(posedge REFCLK) begin
        if (RST) begin
            rdy_m <= '0;
            rdy_s <= '0;
        end else begin
            rdy_m <= ctrl_rdy;
            rdy_s <= rdy_m;
        end
    end

    assign grp_rdy = rdy_s;
    assign all_rdy = &(rdy_s | ~GRP_MASK);

    always_ff @(posedge REFCLK) begin
        if (RST) begin
            state    <= S_HOLD;
            cnt      <= '0;
            retry    <= '0;
            loss_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
            if (loss_inc && loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        retry_nxt = retry;
        loss_inc  = 1'b0;
        unique case (state)
            S_HOLD: begin
                if (recal) begin
                    cnt_nxt = '0;
                end else if (cnt == HOLD_END) begin
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                // Ready wins over a timeout landing in the same cycle.
                if (recal) begin
                    state_nxt = S_HOLD;
                end else if (all_rdy) begin
                    state_nxt = S_LOCKED;
                    retry_nxt = '0;
                end else if (cnt == WAIT_END) begin
                    if (retry == RETRY_LIM) begin
                        state_nxt = S_FAULT;
                    end else begin
                        state_nxt = S_HOLD;
                        retry_nxt = retry + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_LOCKED: begin
                if (!all_rdy) begin
                    state_nxt = S_HOLD;
                    loss_inc  = 1'b1;
                end else if (recal) begin
                    state_nxt = S_HOLD;
                end
            end
            S_FAULT: begin
                if (recal) begin
                    state_nxt = S_HOLD;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = S_HOLD;
        endcase
    end

    // Outputs depend on the state register only, never on inputs.
    always_comb begin
        ctrl_rst  = {NUM_GRP{(state == S_HOLD) || (state == S_FAULT)}};
        RDY       = (state == S_LOCKED);
        fault     = (state == S_FAULT);
        dbg_state = state;
        dbg_retry = retry;
    end

endmodule

// File: tb/tb_idelayctrl_mgr.sv
// Directed bench for idelayctrl_mgr: cycle-by-cycle output expectations derived from the
// documented timing, plus point checks of counters and debug state.
module tb_idelayctrl_mgr;

    logic       REFCLK;
    logic       rst;
    logic       recal;
    logic [1:0] ctrl_rdy;

    logic [1:0] ctrl_rst, grp_rdy;
    logic       rdy_out, fault;
    logic [7:0] loss_cnt;
    logic [1:0] dbg_state;
    logic [3:0] dbg_retry;

    logic [1:0] ctrl_rst2, grp_rdy2;
    logic       rdy_out2, fault2;
    logic [7:0] loss_cnt2;
    logic [1:0] dbg_state2;
    logic [3:0] dbg_retry2;

    logic [7:0] obs_w;
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    idelayctrl_mgr #(
        .NUM_GRP(2), .GRP_MASK(2'b11), .RST_CYCLES(4), .RDY_TIMEOUT(8), .MAX_RETRY(2)
    ) dut (
        .REFCLK(REFCLK), .RST(rst), .recal(recal), .ctrl_rdy(ctrl_rdy),
        .ctrl_rst(ctrl_rst), .RDY(rdy_out), .grp_rdy(grp_rdy), .fault(fault),
        .loss_cnt(loss_cnt), .dbg_state(dbg_state), .dbg_retry(dbg_retry)
    );

    idelayctrl_mgr #(
        .NUM_GRP(2), .GRP_MASK(2'b01), .RST_CYCLES(4), .RDY_TIMEOUT(8), .MAX_RETRY(2)
    ) dut_mask (
        .REFCLK(REFCLK), .RST(rst), .recal(recal), .ctrl_rdy(ctrl_rdy),
        .ctrl_rst(ctrl_rst2), .RDY(rdy_out2), .grp_rdy(grp_rdy2), .fault(fault2),
        .loss_cnt(loss_cnt2), .dbg_state(dbg_state2), .dbg_retry(dbg_retry2)
    );

    assign obs_w = {4'b0, ctrl_rst, rdy_out, fault};

    // Clock / watchdog
    initial begin
        REFCLK = 1'b0;
        forever #5 REFCLK = ~REFCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [7:0] ow(input logic cr, input logic r, input logic f);
        return {4'b0, cr, cr, r, f};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] e);
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge REFCLK);
            #1;
        end
    endtask

    // Queue the expected outputs for the current cycle, sample mid-cycle, move on.
    task automatic tick(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        @(negedge REFCLK);
        chk(tag, obs_w, exp_q.pop_front());
        @(posedge REFCLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},   obs_w,               ow(1'b1, 1'b0, 1'b0));
        chk({tag, "_loss"},  loss_cnt,            8'd0);
        chk({tag, "_state"}, {6'b0, dbg_state},   8'd0);
        chk({tag, "_retry"}, {4'b0, dbg_retry},   8'd0);
        chk({tag, "_grp"},   {6'b0, grp_rdy},     8'd0);
    endtask

    initial begin
        rst      = 1'b1;
        recal    = 1'b0;
        ctrl_rdy = 2'b00;
        adv(1);
        chk_reset_vals("por");
        adv(2);
        rst = 1'b0;

        // Nominal bring-up: cycle 0 is the current cycle
        for (int c = 0; c < 12; c++) begin
            if (c == 5) ctrl_rdy = 2'b11;
            tick("bringup", ow(c < 4, c >= 8, 1'b0));
        end
        chk("bringup_loss",  loss_cnt,            8'd0);
        chk("bringup_state", {6'b0, dbg_state},   8'd2);
        chk("bringup_retry", {4'b0, dbg_retry},   8'd0);
        chk("bringup_grp",   {6'b0, grp_rdy},     8'd3);

        // One-cycle drop of group 1 while locked
        for (int k = 0; k < 10; k++) begin
            ctrl_rdy = (k == 0) ? 2'b01 : 2'b11;
            tick("loss", ow(k >= 3 && k <= 6, k < 3 || k >= 8, 1'b0));
        end
        chk("loss_cnt1",   loss_cnt,          8'd1);
        chk("loss_retry",  {4'b0, dbg_retry}, 8'd0);

        // recal coincides with the cycle the FSM sees the drop
        for (int k = 0; k < 10; k++) begin
            ctrl_rdy = (k == 0) ? 2'b01 : 2'b11;
            recal    = (k == 2);
            tick("simul", ow(k >= 3 && k <= 6, k < 3 || k >= 8, 1'b0));
        end
        recal = 1'b0;
        chk("simul_loss", loss_cnt, 8'd2);

        // Saturation of the loss counter
        repeat (300) begin
            ctrl_rdy = 2'b01;
            adv(1);
            ctrl_rdy = 2'b11;
            adv(9);
        end
        chk("sat_loss", loss_cnt, 8'd255);
        chk("sat_out",  obs_w,    ow(1'b0, 1'b1, 1'b0));

        // Partial ready: three timed-out attempts then FAULT; masked instance locks
        ctrl_rdy = 2'b01;
        rst = 1'b1;
        adv(2);
        chk("rst2_loss", loss_cnt, 8'd0);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 6) begin
                chk("mask_rdy", {7'b0, rdy_out2},   8'd1);
                chk("mask_rst", {6'b0, ctrl_rst2},  8'd0);
                chk("part_grp", {6'b0, grp_rdy},    8'd1);
            end
            if (c == 13) chk("part_retry1", {4'b0, dbg_retry}, 8'd1);
            if (c == 25) chk("part_retry2", {4'b0, dbg_retry}, 8'd2);
            if (c == 37) chk("part_state",  {6'b0, dbg_state}, 8'd3);
            tick("partial", ow(c >= 36 || (c % 12) < 4, 1'b0, c >= 36));
        end

        // Fault recovery by recal
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                recal    = 1'b1;
                ctrl_rdy = 2'b11;
            end else begin
                recal = 1'b0;
            end
            if (k == 1) chk("recover_retry", {4'b0, dbg_retry}, 8'd0);
            tick("recover", ow(k <= 4, k >= 6, k == 0));
        end

        // Persistent partial ready, then recal in WAIT while retry=1
        for (int k = 0; k < 27; k++) begin
            ctrl_rdy = 2'b01;
            recal    = (k == 20);
            if (k == 5)  chk("rw_loss",   loss_cnt,          8'd1);
            if (k == 16) chk("rw_retry",  {4'b0, dbg_retry}, 8'd1);
            if (k == 21) begin
                chk("rw_retry_kept", {4'b0, dbg_retry}, 8'd1);
                chk("rw_state",      {6'b0, dbg_state}, 8'd0);
            end
            tick("recal_wait", ow((k >= 3 && k <= 6) || (k >= 15 && k <= 18) ||
                                  (k >= 21 && k <= 24), k < 3, 1'b0));
        end
        recal = 1'b0;

        // Reset in the middle of WAIT
        rst = 1'b1;
        adv(1);
        chk_reset_vals("rst_wait");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick("rst_wait_seq", ow(c < 4, 1'b0, 1'b0));
        end

        // Reset in cycle 2 of HOLD
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        tick("hold_c0", ow(1'b1, 1'b0, 1'b0));
        tick("hold_c1", ow(1'b1, 1'b0, 1'b0));
        rst = 1'b1;
        adv(1);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) chk("rst_hold_state", {6'b0, dbg_state}, 8'd1);
            tick("rst_hold_seq", ow(c < 4, 1'b0, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
